dsp38_acc_drain: RTL and testbench
==================================

Name: dsp38_acc_drain

Overview:
- Downstream stage of the 38-bit DSP multiply-accumulate slice (20x18 operands, 38-bit z_out).
- Samples the running accumulator at the end of each fixed-length accumulation window, then rounds, shifts and saturates the result to a narrow signed word.
- Pulses a clear back to the accumulator and buffers results in a small first-word-fall-through FIFO with a valid/ready handshake toward the consumer.

Parameters:
- IN_W, 38, accumulator width from the DSP slice (two's complement).
- OUT_W, 16, output word width (signed).
- SHIFT, 16, right-shift applied after rounding; must be at least 1.
- WIN_LEN, 8, number of z_valid samples per accumulation window; must be at least 2.
- FIFO_DEPTH, 4, output FIFO entries; power of two.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- z_in  input  IN_W  accumulator value from the DSP slice (z_out).
- z_valid  input  1  z_in carries a new accumulated sample this cycle.
- acc_clr  output  1  one-cycle pulse that clears the upstream accumulator.
- out_data  output  OUT_W  rounded and saturated window result.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts out_data when out_valid=1.
- sat_flag  output  1  head entry was saturated; travels with out_data.
- overflow  output  1  sticky: a window result was dropped because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset values: acc_clr=0, out_valid=0, out_data=0, sat_flag=0, overflow=0, fifo_count=0, window counter=0, pipeline valid bits=0.
- Window counter:
  - Increments on each z_valid.
  - On z_valid with counter==WIN_LEN-1 (cycle N), z_in is captured into stage-1 and the counter wraps to 0.
  - z_valid=0 holds the counter.
- acc_clr: asserted in cycle N+1 for exactly one cycle.
- Stage 2 (arithmetic, evaluated on stage-1 content):
  - r = sign-extended z_in + 2^(SHIFT-1), computed in IN_W+1 bits (no wrap); this is round-half-up.
  - q = r >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1: out = max positive, sat=1.
  - If q < -2^(OUT_W-1): out = min negative, sat=1.
  - Otherwise out = q[OUT_W-1:0], sat=0.
  - Result is pushed into the FIFO at the end of cycle N+1.
- Latency: out_valid rises in cycle N+2 when the FIFO was empty.
- FIFO (first-word-fall-through):
  - Pop when out_valid && out_ready.
  - Push accepted if not full, or if full and a pop occurs the same cycle.
  - Otherwise the result is dropped, overflow sets and stays set until reset.
  - acc_clr still pulses on a dropped window.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pop on empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Back-to-back windows (WIN_LEN consecutive z_valid cycles) are supported at full rate; the stage-1/stage-2 pipeline never stalls.
- out_data and sat_flag hold stable while out_valid=1 and out_ready=0.
- Reset mid-window or mid-pipeline: counter cleared, in-flight stage-1 result discarded, FIFO emptied, no acc_clr pulse issued.
- z_valid asserted during reset is ignored.

Test Plan:
- Reset check: assert reset for 2 cycles with z_valid=1 -> all outputs 0, no acc_clr; then 8 z_valid with final z_in=38'h00_0001_8000 (98304) -> acc_clr in N+1, out_valid in N+2, out_data=16'd2, sat_flag=0.
- Positive saturation and negative rounding:
  - Final window sample z_in=38'h1F_FFFF_FFFF -> out_data=16'h7FFF, sat_flag=1.
  - Next window final z_in=38'h20_0000_0000 -> out_data=16'h8000, sat_flag=1.
  - Third window final z_in=38'h3F_FFFF_8000 (-32768) -> out_data=16'h0000, sat_flag=0.
- Backpressure and overflow: out_ready=0, run 5 windows -> fifo_count=4, overflow=1, 5 acc_clr pulses; out_ready=1 -> first four results drain in order.
- Full with same-cycle pop: FIFO full, out_ready=1 in the push cycle -> no drop, overflow stays 0, fifo_count stays 4.
- Reset mid-window: 5 z_valid, reset 1 cycle, then 8 z_valid -> exactly one result, taken from the 8th post-reset sample.
- Random: 600 windows with random z_in and random out_ready -> every popped word matches a reference round/shift/saturate model, in order, and drop count equals the overflow cases.

Source files
------------

// File: rtl/dsp38_acc_drain_if.sv
// Handshake bundle between the DSP accumulator, the drain stage and the result consumer.
// The slave modport is the drain stage; the master modport is the surrounding environment.
interface dsp38_acc_drain_if #(
  parameter int IN_W       = 38,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [IN_W-1:0]  z_in;
  logic             z_valid;
  logic             acc_clr;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sat_flag;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output z_in, z_valid, out_ready,
    input  acc_clr, out_data, out_valid, sat_flag, overflow, fifo_count
  );

  modport slave (
    input  z_in, z_valid, out_ready,
    output acc_clr, out_data, out_valid, sat_flag, overflow, fifo_count
  );
endinterface

// File: rtl/dsp38_acc_drain.sv
// Window-end sampler for the 38-bit MAC slice: captures the accumulator every WIN_LEN samples,
// clears it, rounds/shifts/saturates the value and queues it in a small FWFT FIFO.
module dsp38_acc_drain #(
  parameter int IN_W       = 38,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 16,
  parameter int WIN_LEN    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  dsp38_acc_drain_if.slave  bus
);

  localparam int WCNT_W = $clog2(WIN_LEN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic        [IN_W:0] RND     = (IN_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [WCNT_W-1:0] win_cnt_q, win_cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]   s1_data_q, s1_data_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [OUT_W:0]    mem_q [FIFO_DEPTH];

  logic              win_end;
  logic signed [IN_W:0] round_r;
  logic signed [IN_W:0] shift_r;
  logic [OUT_W-1:0]  res_data;
  logic              res_sat;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;

  assign win_end    = bus.z_valid && (win_cnt_q == WCNT_W'(WIN_LEN - 1));
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.out_ready;
  // A full FIFO still takes the new word when the consumer frees a slot in the same cycle.
  assign push_ok    = s1_valid_q && (!fifo_full || pop);

  // Round half up in one extra bit so the bias can never wrap the most positive input.
  always_comb begin
    round_r  = $signed({s1_data_q[IN_W-1], s1_data_q}) + $signed(RND);
    shift_r  = round_r >>> SHIFT;
    res_data = shift_r[OUT_W-1:0];
    res_sat  = 1'b0;
    if (shift_r > SAT_MAX) begin
      res_data = {1'b0, {(OUT_W - 1){1'b1}}};
      res_sat  = 1'b1;
    end else if (shift_r < SAT_MIN) begin
      res_data = {1'b1, {(OUT_W - 1){1'b0}}};
      res_sat  = 1'b1;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    win_cnt_d  = win_cnt_q;
    s1_valid_d = win_end;
    s1_data_d  = s1_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    if (bus.z_valid) begin
      win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;
    end
    if (win_end) begin
      s1_data_d = bus.z_in;
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (s1_valid_q && !push_ok) begin
      ovf_d = 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: datapath storage is not reset; valid bits and the zero-gated read port cover its contents.
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {res_sat, res_data};
    end
  end

  assign bus.acc_clr    = s1_valid_q;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q][OUT_W-1:0];
  assign bus.sat_flag   = fifo_empty ? 1'b0 : mem_q[rd_ptr_q][OUT_W];
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_dsp38_acc_drain.sv
// Directed and model-checked stimulus for dsp38_acc_drain at its default parameters.
module tb_dsp38_acc_drain;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dsp38_acc_drain_if #(.IN_W(38), .OUT_W(16), .FIFO_DEPTH(4)) bus ();

  dsp38_acc_drain #(
    .IN_W(38), .OUT_W(16), .SHIFT(16), .WIN_LEN(8), .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int clr_cnt = 0;
  int clr0;

  // Reference model state for the random phase.
  logic [16:0] mq [$];
  int          mcnt;
  logic        ms1v;
  logic [37:0] ms1z;
  logic        movf;
  int          mwin;
  int          drops;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.acc_clr === 1'b1) clr_cnt++;
  endtask

  task automatic sample(input logic [37:0] v);
    bus.z_valid = 1'b1;
    bus.z_in    = v;
    tick();
    bus.z_valid = 1'b0;
  endtask

  // Seven zero samples then the window-final value; returns in cycle N+1.
  task automatic window(input logic [37:0] v);
    for (int i = 0; i < 7; i++) sample(38'h0);
    sample(v);
  endtask

  // {sat, data} for a window-final accumulator value: round half up, >>16, clamp to 16 bits.
  function automatic logic [16:0] ref_word(input logic [37:0] z);
    longint signed zs;
    longint signed q;
    zs = longint'($signed(z));
    q  = (zs + 64'sd32768) >>> 16;
    if (q > 64'sd32767)  return {1'b1, 16'h7FFF};
    if (q < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic step_rand(input logic zv, input logic [37:0] z, input logic rdy);
    check("rnd_valid", bus.out_valid, mq.size() != 0);
    check("rnd_count", bus.fifo_count, mq.size());
    check("rnd_overflow", bus.overflow, movf);
    check("rnd_acc_clr", bus.acc_clr, ms1v);
    if (mq.size() != 0) check("rnd_head", {bus.sat_flag, bus.out_data}, mq[0]);
    bus.z_valid   = zv;
    bus.z_in      = z;
    bus.out_ready = rdy;
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (ms1v) begin
      if (mq.size() < 4) mq.push_back(ref_word(ms1z));
      else begin
        drops++;
        movf = 1'b1;
      end
    end
    ms1v = zv && (mcnt == 7);
    if (zv) begin
      ms1z = z;
      mcnt = (mcnt == 7) ? 0 : mcnt + 1;
      if (mcnt == 0) mwin++;
    end
    tick();
  endtask

  initial begin
    logic [63:0]  rnd64;
    longint signed sv;
    logic [37:0]  rz;
    int           cyc;

    // Reset with z_valid held high: everything stays at zero.
    reset = 1'b1;
    bus.z_valid = 1'b1;
    bus.z_in = 38'h3F_FFFF_FFFF;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_acc_clr", bus.acc_clr, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, 16'h0);
      check("rst_sat_flag", bus.sat_flag, 1'b0);
      check("rst_overflow", bus.overflow, 1'b0);
      check("rst_fifo_count", bus.fifo_count, 3'd0);
    end
    reset = 1'b0;
    bus.z_valid = 1'b0;

    // First window: 98304 rounds to 2; acc_clr in N+1, out_valid in N+2.
    window(38'h00_0001_8000);
    check("lat_acc_clr_n1", bus.acc_clr, 1'b1);
    check("lat_valid_n1", bus.out_valid, 1'b0);
    tick();
    check("lat_acc_clr_n2", bus.acc_clr, 1'b0);
    check("lat_valid_n2", bus.out_valid, 1'b1);
    check("first_data", bus.out_data, 16'd2);
    check("first_sat", bus.sat_flag, 1'b0);
    check("first_count", bus.fifo_count, 3'd1);
    bus.out_ready = 1'b1;
    tick();
    check("first_popped", bus.out_valid, 1'b0);

    // Saturation both ways and rounding of -32768 to zero.
    window(38'h1F_FFFF_FFFF);
    tick();
    check("sat_pos", {bus.out_valid, bus.sat_flag, bus.out_data}, {2'b11, 16'h7FFF});
    window(38'h20_0000_0000);
    tick();
    check("sat_neg", {bus.out_valid, bus.sat_flag, bus.out_data}, {2'b11, 16'h8000});
    window(38'h3F_FFFF_8000);
    tick();
    check("round_neg", {bus.out_valid, bus.sat_flag, bus.out_data}, {2'b10, 16'h0000});
    tick();

    // Backpressure: five windows into a four-deep FIFO, the fifth is dropped.
    bus.out_ready = 1'b0;
    clr0 = clr_cnt;
    for (int k = 1; k <= 5; k++) window(38'(k) << 16);
    tick();
    check("bp_count", bus.fifo_count, 3'd4);
    check("bp_overflow", bus.overflow, 1'b1);
    check("bp_clr_pulses", clr_cnt - clr0, 5);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp_drain", {bus.out_valid, bus.out_data}, {1'b1, 16'(k)});
      tick();
    end
    check("bp_empty", bus.out_valid, 1'b0);

    // Full FIFO with a pop in the push cycle: nothing dropped.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("full_rst_overflow", bus.overflow, 1'b0);
    bus.out_ready = 1'b0;
    for (int k = 10; k <= 13; k++) window(38'(k) << 16);
    tick();
    check("full_count", bus.fifo_count, 3'd4);
    window(38'(14) << 16);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("full_pp_count", bus.fifo_count, 3'd4);
    check("full_pp_overflow", bus.overflow, 1'b0);
    check("full_pp_head", bus.out_data, 16'd11);
    bus.out_ready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      check("full_drain", {bus.out_valid, bus.out_data}, {1'b1, 16'(k)});
      tick();
    end
    check("full_empty", bus.out_valid, 1'b0);

    // Reset mid-window: the count restarts, the one result comes from post-reset sample 8.
    for (int i = 0; i < 5; i++) sample(38'h5_0000);
    reset = 1'b1;
    bus.z_valid = 1'b1;
    bus.z_in = 38'h9_0000;
    tick();
    reset = 1'b0;
    bus.z_valid = 1'b0;
    check("midrst_acc_clr", bus.acc_clr, 1'b0);
    clr0 = clr_cnt;
    for (int i = 0; i < 7; i++) sample(38'h5_0000);
    sample(38'h7_0000);
    check("midrst_acc_clr_n1", bus.acc_clr, 1'b1);
    tick();
    check("midrst_result", {bus.out_valid, bus.out_data}, {1'b1, 16'd7});
    tick();
    tick();
    check("midrst_single", bus.fifo_count, 3'd0);
    check("midrst_clr_pulses", clr_cnt - clr0, 1);

    // Random windows against the reference model, ready rate alternating between phases.
    reset = 1'b1;
    bus.z_valid = 1'b0;
    tick();
    reset = 1'b0;
    mq.delete();
    mcnt = 0; ms1v = 1'b0; ms1z = '0; movf = 1'b0; mwin = 0; drops = 0;
    cyc = 0;
    while (mwin < 600 && cyc < 40000) begin
      cyc++;
      case ($urandom_range(0, 2))
        0: begin
          rnd64 = {$urandom(), $urandom()};
          rz = rnd64[37:0];
        end
        1: begin
          sv = longint'($urandom_range(0, 33554432)) - 64'sd16777216;
          rz = sv[37:0];
        end
        default: begin
          sv = (($urandom_range(0, 1) == 0) ? -64'sd32768 : 64'sd32767) * 64'sd65536
               + longint'($urandom_range(0, 131071)) - 64'sd65536;
          rz = sv[37:0];
        end
      endcase
      step_rand($urandom_range(0, 3) != 0, rz,
                ((mwin / 50) % 2 == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0));
    end
    check("rnd_windows_done", mwin, 600);
    for (int i = 0; i < 16; i++) step_rand(1'b0, 38'h0, 1'b1);
    check("rnd_drained", bus.fifo_count, 3'd0);
    check("rnd_overflow_matches_drops", bus.overflow, drops != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
